// File: rtl/axi_pkg.sv
// Shared AXI4 constants, response codes, tester FSM states and the AxSIZE encoder.
package axi_pkg;

  localparam logic [1:0]  INCR_BURST_TYPE  = 2'b01;
  localparam int unsigned MAX_BURST_LENGTH = 256;

  localparam int unsigned AXSIZE_W = 3;
  localparam int unsigned PROT_W   = 3;
  localparam int unsigned QOS_W    = 4;
  localparam int unsigned CACHE_W  = 4;
  localparam int unsigned RESP_W   = 2;

  typedef enum logic [RESP_W-1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WADDR,
    S_WDATA,
    S_WRESP,
    S_RADDR,
    S_RDATA,
    S_FIN
  } state_e;

  // Fixed AW/AR attributes shared by both address channels
  typedef struct packed {
    logic [7:0]          len;
    logic [AXSIZE_W-1:0] size;
    logic [1:0]          burst;
    logic                lock;
    logic [CACHE_W-1:0]  cache;
    logic [PROT_W-1:0]   prot;
    logic [QOS_W-1:0]    qos;
  } ax_attr_t;

  function automatic logic [AXSIZE_W-1:0] size_enc(input int unsigned bytes);
    logic [AXSIZE_W-1:0] enc;
    enc = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if ((32'd1 << i) == bytes) enc = AXSIZE_W'(i);
    end
    return enc;
  endfunction

endpackage

// File: rtl/axi_pattern_gen.sv
// Maps a beat byte address to the expected data word: (addr ^ SEED) replicated.
module axi_pattern_gen
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 128,
  parameter logic [31:0] SEED   = 32'hA5A5_0000
) (
  input  logic [ADDR_W-1:0] beat_addr_i,
  output logic [DATA_W-1:0] pattern_o_c
);

  localparam int unsigned WORDS = DATA_W / 32;

  logic [31:0] word_c;

  always_comb begin
    word_c      = 32'(beat_addr_i) ^ SEED;
    pattern_o_c = {WORDS{word_c}};
  end

endmodule

// File: rtl/axi_mem_tester.sv
// AXI4 master that writes an address-derived pattern over a region with INCR
// bursts, reads it back and reports completion, errors and the first bad address.
module axi_mem_tester
  import axi_pkg::*;
#(
  parameter int unsigned C_AXI_ADDR_WIDTH = 12,
  parameter int unsigned C_AXI_DATA_WIDTH = 128,
  parameter int unsigned C_AXI_ID_WIDTH   = 1,
  parameter int unsigned BURST_LEN        = 16,
  parameter int unsigned NUM_BURSTS       = 16,
  parameter int unsigned BASE_ADDR        = 0,
  parameter logic [31:0] SEED             = 32'hA5A5_0000
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [15:0]                   mismatch_count,
  output logic [C_AXI_ADDR_WIDTH-1:0]   first_err_addr,
  output logic [C_AXI_ID_WIDTH-1:0]     m_axi_awid,
  output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                    m_axi_awlen,
  output logic [2:0]                    m_axi_awsize,
  output logic [1:0]                    m_axi_awburst,
  output logic                          m_axi_awlock,
  output logic [3:0]                    m_axi_awcache,
  output logic [2:0]                    m_axi_awprot,
  output logic [3:0]                    m_axi_awqos,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [C_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                          m_axi_wlast,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [C_AXI_ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  output logic [C_AXI_ID_WIDTH-1:0]     m_axi_arid,
  output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic                          m_axi_arlock,
  output logic [3:0]                    m_axi_arcache,
  output logic [2:0]                    m_axi_arprot,
  output logic [3:0]                    m_axi_arqos,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [C_AXI_ID_WIDTH-1:0]     m_axi_rid,
  input  logic [1:0]                    m_axi_rresp,
  input  logic [C_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic                          m_axi_rlast,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  localparam int unsigned BYTES        = C_AXI_DATA_WIDTH / 8;
  localparam int unsigned BURST_BYTES  = BURST_LEN * BYTES;
  localparam int unsigned REGION_BYTES = BURST_BYTES * NUM_BURSTS;
  localparam logic [8:0]  LAST_BEAT    = 9'(BURST_LEN - 1);
  localparam logic [15:0] LAST_BURST   = 16'(NUM_BURSTS - 1);

  localparam ax_attr_t AX_ATTR = '{
    len:   8'(BURST_LEN - 1),
    size:  size_enc(BYTES),
    burst: INCR_BURST_TYPE,
    lock:  1'b0,
    cache: '0,
    prot:  '0,
    qos:   '0
  };

  if (C_AXI_DATA_WIDTH < 32 || C_AXI_DATA_WIDTH > 1024 ||
      (C_AXI_DATA_WIDTH & (C_AXI_DATA_WIDTH - 1)) != 0) begin : g_chk_width
    $error("axi_mem_tester: C_AXI_DATA_WIDTH must be a power of two in 32..1024");
  end
  if (BURST_LEN < 1 || BURST_LEN > MAX_BURST_LENGTH || NUM_BURSTS < 1) begin : g_chk_len
    $error("axi_mem_tester: BURST_LEN must be 1..256 and NUM_BURSTS at least 1");
  end
  if (BURST_BYTES == 0 || (32'd4096 % BURST_BYTES) != 0) begin : g_chk_4k
    $error("axi_mem_tester: BURST_LEN*BYTES must divide 4096");
  end
  if ((64'(BASE_ADDR) + 64'(REGION_BYTES)) > (64'd1 << C_AXI_ADDR_WIDTH)) begin : g_chk_region
    $error("axi_mem_tester: test region exceeds the address space");
  end
  if (BURST_BYTES != 0 && (BASE_ADDR % BURST_BYTES) != 0) begin : g_chk_align
    $error("axi_mem_tester: BASE_ADDR must be aligned to BURST_LEN*BYTES");
  end

  state_e state_q, state_d;

  logic [8:0]                  beat_q, beat_d;
  logic [15:0]                 burst_q, burst_d;
  logic [C_AXI_ADDR_WIDTH-1:0] addr_q, addr_c;
  logic [C_AXI_DATA_WIDTH-1:0] exp_q, pattern_c;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, wlast_q, wlast_d;
  logic bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
  logic busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [15:0]                 cnt_q, cnt_d;
  logic [C_AXI_ADDR_WIDTH-1:0] first_q, first_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic beat_last, burst_last, start_acc, fail_c;
  logic unused_c;

  assign aw_hs      = awvalid_q & m_axi_awready;
  assign w_hs       = wvalid_q & m_axi_wready;
  assign b_hs       = bready_q & m_axi_bvalid;
  assign ar_hs      = arvalid_q & m_axi_arready;
  assign r_hs       = rready_q & m_axi_rvalid;
  assign beat_last  = (beat_q == LAST_BEAT);
  assign burst_last = (burst_q == LAST_BURST);
  assign start_acc  = start & ((state_q == S_IDLE) | (state_q == S_FIN));
  assign unused_c   = ^{m_axi_bid, m_axi_rid};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_FIN: if (start)               state_d = S_WADDR;
      S_WADDR:       if (aw_hs)               state_d = S_WDATA;
      S_WDATA:       if (w_hs && beat_last)   state_d = S_WRESP;
      S_WRESP:       if (b_hs)                state_d = burst_last ? S_RADDR : S_WADDR;
      S_RADDR:       if (ar_hs)               state_d = S_RDATA;
      S_RDATA:       if (r_hs && beat_last)   state_d = burst_last ? S_FIN : S_RADDR;
      default:                                state_d = S_IDLE;
    endcase
  end

  // Channel controls are registered from the next state
  always_comb begin
    awvalid_d = (state_d == S_WADDR);
    wvalid_d  = (state_d == S_WDATA);
    wlast_d   = (state_d == S_WDATA) && (beat_d == LAST_BEAT);
    bready_d  = (state_d == S_WRESP);
    arvalid_d = (state_d == S_RADDR);
    rready_d  = (state_d == S_RDATA);
    busy_d    = (state_d != S_IDLE) && (state_d != S_FIN);
    done_d    = done_q;
    if (start_acc)          done_d = 1'b0;
    if (state_d == S_FIN)   done_d = 1'b1;
  end

  // Beat/burst counters; a missing rlast never stalls, the beat count ends a burst
  always_comb begin
    beat_d  = beat_q;
    burst_d = burst_q;
    if (start_acc) begin
      beat_d  = '0;
      burst_d = '0;
    end else if ((state_q == S_WDATA && w_hs) || (state_q == S_RDATA && r_hs)) begin
      beat_d = beat_last ? 9'd0 : beat_q + 9'd1;
      if (state_q == S_RDATA && beat_last) burst_d = burst_last ? 16'd0 : burst_q + 16'd1;
    end else if (state_q == S_WRESP && b_hs) begin
      burst_d = burst_last ? 16'd0 : burst_q + 16'd1;
    end
    addr_c = C_AXI_ADDR_WIDTH'(BASE_ADDR + (32'(burst_d) * BURST_LEN + 32'(beat_d)) * BYTES);
  end

  axi_pattern_gen #(
    .ADDR_W (C_AXI_ADDR_WIDTH),
    .DATA_W (C_AXI_DATA_WIDTH),
    .SEED   (SEED)
  ) u_pattern (
    .beat_addr_i (addr_c),
    .pattern_o_c (pattern_c)
  );

  // Error tracking; addr_q is the burst base during WRESP
  always_comb begin
    fail_c = 1'b0;
    if (b_hs && m_axi_bresp != RESP_OKAY) fail_c = 1'b1;
    if (r_hs && (m_axi_rresp != RESP_OKAY || m_axi_rdata != exp_q || m_axi_rlast != beat_last))
      fail_c = 1'b1;
    error_d = error_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    if (start_acc) begin
      error_d = 1'b0;
      cnt_d   = '0;
      first_d = '0;
    end else if (fail_c) begin
      error_d = 1'b1;
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      if (!error_q)          first_d = addr_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      wlast_q   <= wlast_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      beat_q  <= '0;
      burst_q <= '0;
      addr_q  <= '0;
      exp_q   <= '0;
      error_q <= 1'b0;
      cnt_q   <= '0;
      first_q <= '0;
    end else begin
      beat_q  <= beat_d;
      burst_q <= burst_d;
      addr_q  <= addr_c;
      exp_q   <= pattern_c;
      error_q <= error_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign mismatch_count = cnt_q;
  assign first_err_addr = first_q;

  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = AX_ATTR.len;
  assign m_axi_awsize  = AX_ATTR.size;
  assign m_axi_awburst = AX_ATTR.burst;
  assign m_axi_awlock  = AX_ATTR.lock;
  assign m_axi_awcache = AX_ATTR.cache;
  assign m_axi_awprot  = AX_ATTR.prot;
  assign m_axi_awqos   = AX_ATTR.qos;
  assign m_axi_awvalid = awvalid_q;

  assign m_axi_wdata  = exp_q;
  assign m_axi_wstrb  = '1;
  assign m_axi_wlast  = wlast_q;
  assign m_axi_wvalid = wvalid_q;
  assign m_axi_bready = bready_q;

  assign m_axi_arid    = '0;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = AX_ATTR.len;
  assign m_axi_arsize  = AX_ATTR.size;
  assign m_axi_arburst = AX_ATTR.burst;
  assign m_axi_arlock  = AX_ATTR.lock;
  assign m_axi_arcache = AX_ATTR.cache;
  assign m_axi_arprot  = AX_ATTR.prot;
  assign m_axi_arqos   = AX_ATTR.qos;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_mem_tester.sv
// Directed bench for axi_mem_tester (4-beat bursts x 2) with a small fault-injecting RAM slave.
module tb_axi_mem_tester;

  logic         clk, resetn, start;
  logic         busy, done, error;
  logic [15:0]  mismatch_count;
  logic [11:0]  first_err_addr;
  logic [0:0]   awid, arid, bid, rid;
  logic [11:0]  awaddr, araddr;
  logic [7:0]   awlen, arlen;
  logic [2:0]   awsize, arsize, awprot, arprot;
  logic [1:0]   awburst, arburst, bresp, rresp;
  logic         awlock, arlock;
  logic [3:0]   awcache, arcache, awqos, arqos;
  logic         awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic         arvalid, arready, rvalid, rready, rlast;
  logic [127:0] wdata, rdata;
  logic [15:0]  wstrb;

  int checks = 0;
  int failures = 0;

  int aw_stall_cfg, slverr_addr, flip_a0, flip_a1, rlast_addr;

  logic [127:0] mem [0:255];
  int           aw_wait, aw_hs_cnt, r_hs_cnt, w_early, cyc, last_r_cyc, raddr;
  logic         w_act, b_pend, r_act;
  logic [7:0]   w_idx, r_idx, r_len;
  logic [8:0]   r_cnt;
  logic [11:0]  last_aw, last_ar;

  axi_mem_tester #(
    .C_AXI_ADDR_WIDTH (12), .C_AXI_DATA_WIDTH (128), .C_AXI_ID_WIDTH (1),
    .BURST_LEN (4), .NUM_BURSTS (2), .BASE_ADDR (0), .SEED (32'hA5A5_0000)
  ) dut (
    .clk (clk), .resetn (resetn), .start (start),
    .busy (busy), .done (done), .error (error),
    .mismatch_count (mismatch_count), .first_err_addr (first_err_addr),
    .m_axi_awid (awid), .m_axi_awaddr (awaddr), .m_axi_awlen (awlen),
    .m_axi_awsize (awsize), .m_axi_awburst (awburst), .m_axi_awlock (awlock),
    .m_axi_awcache (awcache), .m_axi_awprot (awprot), .m_axi_awqos (awqos),
    .m_axi_awvalid (awvalid), .m_axi_awready (awready),
    .m_axi_wdata (wdata), .m_axi_wstrb (wstrb), .m_axi_wlast (wlast),
    .m_axi_wvalid (wvalid), .m_axi_wready (wready),
    .m_axi_bid (bid), .m_axi_bresp (bresp), .m_axi_bvalid (bvalid), .m_axi_bready (bready),
    .m_axi_arid (arid), .m_axi_araddr (araddr), .m_axi_arlen (arlen),
    .m_axi_arsize (arsize), .m_axi_arburst (arburst), .m_axi_arlock (arlock),
    .m_axi_arcache (arcache), .m_axi_arprot (arprot), .m_axi_arqos (arqos),
    .m_axi_arvalid (arvalid), .m_axi_arready (arready),
    .m_axi_rid (rid), .m_axi_rresp (rresp), .m_axi_rdata (rdata),
    .m_axi_rlast (rlast), .m_axi_rvalid (rvalid), .m_axi_rready (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave responder: RAM plus optional stall and R-channel fault injection
  always_comb begin
    raddr   = (int'(r_idx) + int'(r_cnt)) * 16;
    awready = awvalid && (aw_wait >= aw_stall_cfg);
    wready  = w_act;
    bvalid  = b_pend;
    bresp   = 2'b00;
    bid     = 1'b0;
    arready = !r_act;
    rvalid  = r_act;
    rid     = 1'b0;
    rdata   = mem[8'(int'(r_idx) + int'(r_cnt))];
    if (raddr == flip_a0 || raddr == flip_a1) rdata[0] = ~rdata[0];
    rresp   = (raddr == slverr_addr) ? 2'b10 : 2'b00;
    rlast   = (r_cnt[7:0] == r_len) ^ (raddr == rlast_addr);
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_wait <= 0; w_act <= 1'b0; b_pend <= 1'b0; r_act <= 1'b0;
      w_idx <= '0; r_idx <= '0; r_len <= '0; r_cnt <= '0;
      aw_hs_cnt <= 0; r_hs_cnt <= 0; w_early <= 0; cyc <= 0; last_r_cyc <= 0;
      last_aw <= '0; last_ar <= '0;
    end else begin
      cyc <= cyc + 1;
      if (awvalid && !awready) aw_wait <= aw_wait + 1;
      if (awvalid && awready) begin
        aw_wait <= 0; w_act <= 1'b1; w_idx <= awaddr[11:4];
        aw_hs_cnt <= aw_hs_cnt + 1; last_aw <= awaddr;
      end
      if (wvalid && !w_act) w_early <= w_early + 1;
      if (wvalid && wready) begin
        mem[w_idx] <= wdata;
        w_idx <= w_idx + 8'd1;
        if (wlast) begin w_act <= 1'b0; b_pend <= 1'b1; end
      end
      if (bvalid && bready) b_pend <= 1'b0;
      if (arvalid && arready) begin
        r_act <= 1'b1; r_idx <= araddr[11:4]; r_cnt <= '0; r_len <= arlen; last_ar <= araddr;
      end
      if (rvalid && rready) begin
        r_hs_cnt <= r_hs_cnt + 1; last_r_cyc <= cyc; r_cnt <= r_cnt + 9'd1;
        if (r_cnt[7:0] == r_len) r_act <= 1'b0;
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(output bit tmo, output int dcyc);
    tmo = 1'b1;
    dcyc = -1;
    for (int n = 0; n < 2000; n++) begin
      if (done === 1'b1) begin
        tmo = 1'b0;
        dcyc = cyc - last_r_cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, error, awvalid, wvalid, bready, arvalid, rready, mismatch_count, first_err_addr} !== '0) begin
      failures++;
      $display("FAIL reset_in_reset got busy=%b done=%b err=%b awv=%b wv=%b br=%b arv=%b rr=%b cnt=%h first=%h exp all 0",
               busy, done, error, awvalid, wvalid, bready, arvalid, rready, mismatch_count, first_err_addr);
    end
    @(negedge clk); resetn = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, error, awvalid, arvalid, mismatch_count} !== '0) begin
      failures++;
      $display("FAIL reset_idle got busy=%b done=%b err=%b awv=%b arv=%b cnt=%h exp all 0",
               busy, done, error, awvalid, arvalid, mismatch_count);
    end
  endtask

  task automatic test_basic();
    bit tmo; int dcyc;
    pulse_start();
    checks++;
    if (busy !== 1'b1 || awvalid !== 1'b1) begin
      failures++; $display("FAIL basic_after_start got busy=%b awvalid=%b exp 1 1", busy, awvalid);
    end
    wait_done(tmo, dcyc);
    checks++;
    if (tmo !== 1'b0) begin failures++; $display("FAIL basic_timeout got timeout=%b exp 0", tmo); end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0 || mismatch_count !== 16'd0) begin
      failures++;
      $display("FAIL basic_status got done=%b busy=%b err=%b cnt=%0d exp 1 0 0 0", done, busy, error, mismatch_count);
    end
    checks++;
    if (dcyc !== 1) begin failures++; $display("FAIL basic_done_latency got %0d exp 1", dcyc); end
    checks++;
    if (mem[0] !== {4{32'hA5A50000}} || mem[1] !== {4{32'hA5A50010}}) begin
      failures++; $display("FAIL basic_mem_lo got %h %h exp A5A50000x4 A5A50010x4", mem[0], mem[1]);
    end
    checks++;
    if (mem[4] !== {4{32'hA5A50040}} || mem[7] !== {4{32'hA5A50070}}) begin
      failures++; $display("FAIL basic_mem_hi got %h %h exp A5A50040x4 A5A50070x4", mem[4], mem[7]);
    end
    checks++;
    if (aw_hs_cnt !== 2 || r_hs_cnt !== 8 || last_aw !== 12'h040 || last_ar !== 12'h040) begin
      failures++;
      $display("FAIL basic_traffic got aw=%0d r=%0d last_aw=%h last_ar=%h exp 2 8 040 040",
               aw_hs_cnt, r_hs_cnt, last_aw, last_ar);
    end
    checks++;
    if ({awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos, wstrb} !==
        {1'b0, 8'd3, 3'd4, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 16'hFFFF} ||
        {arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos} !==
        {1'b0, 8'd3, 3'd4, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0}) begin
      failures++;
      $display("FAIL basic_fields got awlen=%0d awsize=%0d awburst=%0d arlen=%0d arsize=%0d wstrb=%h exp 3 4 1 3 4 FFFF",
               awlen, awsize, awburst, arlen, arsize, wstrb);
    end
  endtask

  task automatic test_aw_stall();
    bit tmo; int dcyc; int early0;
    aw_stall_cfg = 3;
    early0 = w_early;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (awvalid !== 1'b1 || awaddr !== 12'h000 || wvalid !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold[%0d] got awvalid=%b awaddr=%h wvalid=%b exp 1 000 0", i, awvalid, awaddr, wvalid);
      end
      @(negedge clk);
    end
    wait_done(tmo, dcyc);
    checks++;
    if (tmo !== 1'b0 || error !== 1'b0 || w_early !== early0) begin
      failures++;
      $display("FAIL stall_result got timeout=%b err=%b early_w=%0d exp 0 0 %0d", tmo, error, w_early, early0);
    end
    aw_stall_cfg = 0;
  endtask

  task automatic test_slverr();
    bit tmo; int dcyc;
    slverr_addr = 'h60;
    pulse_start();
    wait_done(tmo, dcyc);
    checks++;
    if (tmo !== 1'b0 || done !== 1'b1) begin
      failures++; $display("FAIL slverr_done got timeout=%b done=%b exp 0 1", tmo, done);
    end
    checks++;
    if (error !== 1'b1 || mismatch_count !== 16'd1 || first_err_addr !== 12'h060) begin
      failures++;
      $display("FAIL slverr_report got err=%b cnt=%0d first=%h exp 1 1 060", error, mismatch_count, first_err_addr);
    end
    slverr_addr = -1;
  endtask

  task automatic test_flip();
    bit tmo; int dcyc;
    flip_a0 = 'h10;
    flip_a1 = 'h50;
    pulse_start();
    wait_done(tmo, dcyc);
    checks++;
    if (tmo !== 1'b0 || error !== 1'b1 || mismatch_count !== 16'd2 || first_err_addr !== 12'h010) begin
      failures++;
      $display("FAIL flip_report got timeout=%b err=%b cnt=%0d first=%h exp 0 1 2 010",
               tmo, error, mismatch_count, first_err_addr);
    end
    flip_a0 = -1;
    flip_a1 = -1;
  endtask

  task automatic test_rlast();
    bit tmo; int dcyc; int r0;
    rlast_addr = 'h10;
    r0 = r_hs_cnt;
    pulse_start();
    wait_done(tmo, dcyc);
    checks++;
    if (tmo !== 1'b0 || done !== 1'b1 || r_hs_cnt - r0 !== 8) begin
      failures++; $display("FAIL rlast_finish got timeout=%b done=%b rbeats=%0d exp 0 1 8", tmo, done, r_hs_cnt - r0);
    end
    checks++;
    if (error !== 1'b1 || first_err_addr !== 12'h010 || mismatch_count !== 16'd1) begin
      failures++;
      $display("FAIL rlast_report got err=%b first=%h cnt=%0d exp 1 010 1", error, first_err_addr, mismatch_count);
    end
    rlast_addr = -1;
  endtask

  task automatic test_back_to_back();
    bit tmo; int dcyc; bit seen;
    pulse_start();
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      if (wvalid === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL midpass_reach_wdata got wvalid=%b exp 1", wvalid); end
    resetn = 1'b0;
    #1;
    checks++;
    if ({busy, done, error, awvalid, wvalid, wlast, bready, arvalid, rready, mismatch_count, first_err_addr} !== '0) begin
      failures++;
      $display("FAIL midpass_async_reset got busy=%b done=%b err=%b awv=%b wv=%b wl=%b br=%b arv=%b rr=%b exp all 0",
               busy, done, error, awvalid, wvalid, wlast, bready, arvalid, rready);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    pulse_start();
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      if (rready === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(tmo, dcyc);
    checks++;
    if (tmo !== 1'b0 || !seen) begin
      failures++; $display("FAIL restart_timeout got timeout=%b reached_rdata=%b exp 0 1", tmo, seen);
    end
    checks++;
    if (aw_hs_cnt !== 2 || r_hs_cnt !== 8) begin
      failures++; $display("FAIL busy_start_ignored got aw=%0d r=%0d exp 2 8", aw_hs_cnt, r_hs_cnt);
    end
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || mismatch_count !== 16'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL restart_clean got done=%b err=%b cnt=%0d busy=%b exp 1 0 0 0", done, error, mismatch_count, busy);
    end
  endtask

  initial begin
    resetn       = 1'b0;
    start        = 1'b0;
    aw_stall_cfg = 0;
    slverr_addr  = -1;
    flip_a0      = -1;
    flip_a1      = -1;
    rlast_addr   = -1;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_aw_stall();
    test_slverr();
    test_flip();
    test_rlast();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
